rgb_pwm_gen: RTL and testbench

RGB_PWM_GEN -- requirements
Module: rgb_pwm_gen

---
 rtl/minivan_pkg.sv | 20 ++
 rtl/pwm_chan.sv | 38 +++
 rtl/rgb_pwm_gen.sv | 118 +++++++++++
 tb/tb_rgb_pwm_gen.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/minivan_pkg.sv
// Shared types and constants for the RGB PWM generator.
package minivan_pkg;

   // Width of the PWM period counter and of each duty value
   localparam int PWM_W = 8;

   // Packed duty configuration as it arrives from the register block
   typedef struct packed {
      logic [PWM_W-1:0] pwm_red;
      logic [PWM_W-1:0] pwm_green;
      logic [PWM_W-1:0] pwm_blue;
   } rb_pwm_cfg_wire_t;

   // Generator state: parked with everything cleared, or producing periods
   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } pwm_state_e;

endpackage

// File: rtl/pwm_chan.sv
// One PWM channel: duty compare against the shared period counter plus the
// output register, with optional active-low polarity.
module pwm_chan
   import minivan_pkg::*;
#(
   parameter bit INVERT = 1'b0
) (
   input  logic             clk,
   input  logic             resetb,
   input  logic             active_en,
   input  logic [PWM_W-1:0] cnt,
   input  logic [PWM_W-1:0] duty,
   output logic             led
);

   logic led_d;
   logic led_q;

   // Active while the counter is below the duty; inactive whenever the generator is not running next cycle
   always_comb begin
      led_d = INVERT;
      if (active_en) begin
         led_d = (cnt < duty) ^ INVERT;
      end
   end

   // Output register; reset drives the inactive level without waiting for clk
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         led_q <= INVERT;
      end else begin
         led_q <= led_d;
      end
   end

   assign led = led_q;

endmodule

// File: rtl/rgb_pwm_gen.sv
// Three-channel PWM generator: prescaler, 8-bit period counter, IDLE/RUN
// control and period-aligned shadow duty registers feeding three channels.
module rgb_pwm_gen
   import minivan_pkg::*;
#(
   parameter int unsigned PRESC  = 4,
   parameter bit          INVERT = 1'b0
) (
   input  logic             clk,
   input  logic             resetb,
   input  logic             enable,
   input  rb_pwm_cfg_wire_t pwm_cfg,
   output logic             led_r,
   output logic             led_g,
   output logic             led_b,
   output logic             period_start,
   output logic             running
);

   localparam int unsigned      PW        = (PRESC > 1) ? $clog2(PRESC) : 1;
   localparam logic [PW-1:0]    PRESC_MAX = PW'(PRESC - 1);
   localparam logic [PWM_W-1:0] CNT_MAX   = '1;

   pwm_state_e       state_q, state_d;
   logic [PW-1:0]    presc_q, presc_d;
   logic [PWM_W-1:0] cnt_q, cnt_d;
   rb_pwm_cfg_wire_t shadow_q, shadow_d;
   logic             period_start_q, period_start_d;
   logic             tick;
   logic             run_next;

   // Next-state, counters and shadow capture; leaving RUN lets everything fall back to zero
   always_comb begin
      // NOTE: every variable gets a default before the case so no path can infer a latch.
      state_d        = state_q;
      presc_d        = '0;
      cnt_d          = '0;
      shadow_d       = shadow_q;
      period_start_d = 1'b0;
      tick           = 1'b0;
      run_next       = 1'b0;
      case (state_q)
         IDLE: begin
            // Keep tracking the config so a new run starts with the latest duties
            shadow_d = pwm_cfg;
            if (enable) begin
               state_d = RUN;
            end
         end
         RUN: begin
            if (!enable) begin
               state_d = IDLE;
            end else begin
               run_next       = 1'b1;
               tick           = (presc_q == PRESC_MAX);
               presc_d        = tick ? '0 : presc_q + 1'b1;
               cnt_d          = tick ? cnt_q + 1'b1 : cnt_q;
               // Duties change only at the 255->0 wrap so a period is never split
               if (tick && (cnt_q == CNT_MAX)) begin
                  shadow_d = pwm_cfg;
               end
               // First step of a period; registered so it lines up with the first LED output
               period_start_d = (cnt_q == '0) && (presc_q == '0);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State registers with asynchronous clear
   always_ff @(posedge clk or negedge resetb) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
      if (!resetb) begin
         state_q        <= IDLE;
         presc_q        <= '0;
         cnt_q          <= '0;
         shadow_q       <= '0;
         period_start_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         presc_q        <= presc_d;
         cnt_q          <= cnt_d;
         shadow_q       <= shadow_d;
         period_start_q <= period_start_d;
      end
   end

   pwm_chan #(.INVERT(INVERT)) u_chan_r (
      .clk       (clk),
      .resetb    (resetb),
      .active_en (run_next),
      .cnt       (cnt_q),
      .duty      (shadow_q.pwm_red),
      .led       (led_r)
   );

   pwm_chan #(.INVERT(INVERT)) u_chan_g (
      .clk       (clk),
      .resetb    (resetb),
      .active_en (run_next),
      .cnt       (cnt_q),
      .duty      (shadow_q.pwm_green),
      .led       (led_g)
   );

   pwm_chan #(.INVERT(INVERT)) u_chan_b (
      .clk       (clk),
      .resetb    (resetb),
      .active_en (run_next),
      .cnt       (cnt_q),
      .duty      (shadow_q.pwm_blue),
      .led       (led_b)
   );

   assign period_start = period_start_q;
   assign running      = (state_q == RUN);

endmodule

// File: tb/tb_rgb_pwm_gen.sv
// Testbench for rgb_pwm_gen: three instances (PRESC=4, PRESC=1, PRESC=4
// active-low). Stimulus pushes expected per-period high counts; a monitor
// measures each completed period between period_start pulses and scores it.
module tb_rgb_pwm_gen;
   import minivan_pkg::*;

   typedef struct packed {
      int r;
      int g;
      int b;
      int len;
   } per_t;

   logic             clk;
   logic             resetb;
   logic             en           [3];
   rb_pwm_cfg_wire_t cfg          [3];
   logic             led_r        [3];
   logic             led_g        [3];
   logic             led_b        [3];
   logic             period_start [3];
   logic             running      [3];

   per_t exp_q [3][$];
   int   hr [3];
   int   hg [3];
   int   hb [3];
   int   len [3];
   bit   in_per [3];
   int   n_tests = 0;
   int   n_fail  = 0;

   rgb_pwm_gen #(.PRESC(4), .INVERT(1'b0)) dut0 (
      .clk(clk), .resetb(resetb), .enable(en[0]), .pwm_cfg(cfg[0]),
      .led_r(led_r[0]), .led_g(led_g[0]), .led_b(led_b[0]),
      .period_start(period_start[0]), .running(running[0])
   );

   rgb_pwm_gen #(.PRESC(1), .INVERT(1'b0)) dut1 (
      .clk(clk), .resetb(resetb), .enable(en[1]), .pwm_cfg(cfg[1]),
      .led_r(led_r[1]), .led_g(led_g[1]), .led_b(led_b[1]),
      .period_start(period_start[1]), .running(running[1])
   );

   rgb_pwm_gen #(.PRESC(4), .INVERT(1'b1)) dut2 (
      .clk(clk), .resetb(resetb), .enable(en[2]), .pwm_cfg(cfg[2]),
      .led_r(led_r[2]), .led_g(led_g[2]), .led_b(led_b[2]),
      .period_start(period_start[2]), .running(running[2])
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no completion, expected summary before 1000000 time units");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic push(input int i, input int r, input int g, input int b, input int l);
      per_t e;
      e.r   = r;
      e.g   = g;
      e.b   = b;
      e.len = l;
      exp_q[i].push_back(e);
   endtask

   task automatic score(input int i);
      per_t e;
      if (exp_q[i].size() == 0) begin
         check($sformatf("dut%0d period_expected", i), exp_q[i].size(), 1);
         return;
      end
      e = exp_q[i].pop_front();
      check($sformatf("dut%0d period_len", i), len[i], e.len);
      check($sformatf("dut%0d r_high", i), hr[i], e.r);
      check($sformatf("dut%0d g_high", i), hg[i], e.g);
      check($sformatf("dut%0d b_high", i), hb[i], e.b);
   endtask

   task automatic wait_ps(input int i, input int budget);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (period_start[i] !== 1'b1 && n < budget);
      check($sformatf("dut%0d period_start_seen", i), period_start[i], 1);
   endtask

   // Monitor: accumulate high cycles per period, score when the next period starts
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (resetb !== 1'b1 || running[i] !== 1'b1) begin
            in_per[i] = 1'b0;
         end else begin
            if (period_start[i] === 1'b1) begin
               if (in_per[i]) score(i);
               in_per[i] = 1'b1;
               hr[i]  = 0;
               hg[i]  = 0;
               hb[i]  = 0;
               len[i] = 0;
            end
            if (in_per[i]) begin
               len[i]++;
               if (led_r[i] === 1'b1) hr[i]++;
               if (led_g[i] === 1'b1) hg[i]++;
               if (led_b[i] === 1'b1) hb[i]++;
            end
         end
      end
   end

   initial begin
      resetb = 1'b1;
      for (int i = 0; i < 3; i++) begin
         en[i]  = 1'b0;
         cfg[i] = '0;
      end
      #1 resetb = 1'b0;
      #2;
      // Asynchronous reset state, before any clock edge
      for (int i = 0; i < 3; i++) begin
         check($sformatf("dut%0d rst led_r", i), led_r[i], (i == 2));
         check($sformatf("dut%0d rst led_g", i), led_g[i], (i == 2));
         check($sformatf("dut%0d rst led_b", i), led_b[i], (i == 2));
         check($sformatf("dut%0d rst period_start", i), period_start[i], 0);
         check($sformatf("dut%0d rst running", i), running[i], 0);
      end
      repeat (2) @(negedge clk);
      #2 resetb = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         check($sformatf("dut%0d idle running", i), running[i], 0);
         check($sformatf("dut%0d idle led_r", i), led_r[i], (i == 2));
      end

      // PRESC=1: duty 255 high 255 of 256, duty 0 never, duty 1 one cycle
      cfg[1] = {8'd255, 8'd0, 8'd1};
      push(1, 255, 0, 1, 256);
      push(1, 255, 0, 1, 256);
      en[1] = 1'b1;
      wait_ps(1, 10);
      wait_ps(1, 300);
      wait_ps(1, 300);
      en[1] = 1'b0;
      @(negedge clk);
      check("dut1 stop running", running[1], 0);

      // Active-low channel, duty 128: low for 512 cycles then high
      cfg[2] = {8'd128, 8'd128, 8'd128};
      push(2, 512, 512, 512, 1024);
      en[2] = 1'b1;
      wait_ps(2, 10);
      check("dut2 first led_r", led_r[2], 0);
      repeat (511) @(negedge clk);
      check("dut2 last active led_g", led_g[2], 0);
      @(negedge clk);
      check("dut2 first inactive led_g", led_g[2], 1);
      wait_ps(2, 1024);
      en[2] = 1'b0;
      @(negedge clk);
      check("dut2 stop led_r", led_r[2], 1);
      check("dut2 stop running", running[2], 0);

      // PRESC=4: r=64, g=128, b=0, then red changed to 200 mid-period
      cfg[0] = {8'd64, 8'd128, 8'd0};
      push(0, 256, 512, 0, 1024);
      push(0, 256, 512, 0, 1024);
      push(0, 800, 512, 0, 1024);
      en[0] = 1'b1;
      wait_ps(0, 10);
      wait_ps(0, 1100);
      repeat (400) @(negedge clk);
      check("dut0 cnt100 led_r", led_r[0], 0);
      cfg[0].pwm_red = 8'd200;
      wait_ps(0, 1100);
      wait_ps(0, 1100);
      repeat (148) @(negedge clk);
      check("dut0 cnt37 led_r", led_r[0], 1);
      check("dut0 cnt37 led_g", led_g[0], 1);
      en[0] = 1'b0;
      @(negedge clk);
      check("dut0 abort running", running[0], 0);
      check("dut0 abort period_start", period_start[0], 0);
      check("dut0 abort led_r", led_r[0], 0);
      check("dut0 abort led_g", led_g[0], 0);
      check("dut0 abort led_b", led_b[0], 0);

      // Re-enable: period restarts from cnt 0 with a period_start pulse
      repeat (3) @(negedge clk);
      en[0] = 1'b1;
      @(negedge clk);
      check("dut0 reentry running", running[0], 1);
      check("dut0 reentry period_start early", period_start[0], 0);
      @(negedge clk);
      check("dut0 reentry period_start", period_start[0], 1);
      check("dut0 reentry led_r", led_r[0], 1);
      repeat (40) @(negedge clk);
      check("dut0 pre-reset led_g", led_g[0], 1);

      // Asynchronous reset mid-period, observed before the next clock edge
      #3 resetb = 1'b0;
      #1;
      check("dut0 async led_r", led_r[0], 0);
      check("dut0 async led_g", led_g[0], 0);
      check("dut0 async running", running[0], 0);
      check("dut0 async period_start", period_start[0], 0);
      check("dut2 async led_r", led_r[2], 1);
      @(negedge clk);
      #2 resetb = 1'b1;
      push(0, 800, 512, 0, 1024);
      wait_ps(0, 10);
      wait_ps(0, 1100);
      en[0] = 1'b0;
      @(negedge clk);
      check("dut0 final running", running[0], 0);

      for (int i = 0; i < 3; i++) begin
         check($sformatf("dut%0d leftover expectations", i), exp_q[i].size(), 0);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
